// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares one combinational RV32I ALU between two requesters. A round-robin
//   pointer breaks ties, the winner's fields are steered onto the ALU ports,
//   and the ALU answer is captured into a 1-entry output register tagged with
//   the requester index. Illegal operation codes return a zero result and
//   bump a saturating counter.
// Ports
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (bit i = requester i)
//   req{0,1}_lhs/rhs       operands (rs1, rs2 or immediate)
//   req{0,1}_op/meta       funct3 / funct7
//   alu_*                  operands to and answer from the shared ALU
//   out_valid/out_ready    registered result handshake
//   out_result/id/illegal  result (0 if illegal), requester index, illegal flag
//   illegal_count          saturating count of accepted illegal operations
module alu_issue_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_lhs,
  input  logic [DATA_WIDTH-1:0] req0_rhs,
  input  logic [2:0]            req0_op,
  input  logic [6:0]            req0_meta,
  input  logic [DATA_WIDTH-1:0] req1_lhs,
  input  logic [DATA_WIDTH-1:0] req1_rhs,
  input  logic [2:0]            req1_op,
  input  logic [6:0]            req1_meta,
  output logic [DATA_WIDTH-1:0] alu_lhs,
  output logic [DATA_WIDTH-1:0] alu_rhs,
  output logic [2:0]            alu_operation,
  output logic [6:0]            alu_metadata,
  output logic                  alu_in_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_code_legal,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_id,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  illegal_count
);

  logic ptr_q;
  logic grant_any;
  logic grant_id;
  logic can_accept;
  logic accept;

  always_comb begin
    grant_any  = |req_valid;
    // A lone requester wins outright; a tie goes to the pointer.
    grant_id   = (&req_valid) ? ptr_q : req_valid[1];
    // Output register frees up in the same cycle it drains.
    can_accept = !out_valid || out_ready;
    accept     = grant_any && can_accept;

    req_ready = 2'b00;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end

    alu_in_valid  = grant_any;
    alu_lhs       = '0;
    alu_rhs       = '0;
    alu_operation = 3'b000;
    alu_metadata  = 7'b0000000;
    if (grant_any) begin
      if (grant_id) begin
        alu_lhs       = req1_lhs;
        alu_rhs       = req1_rhs;
        alu_operation = req1_op;
        alu_metadata  = req1_meta;
      end else begin
        alu_lhs       = req0_lhs;
        alu_rhs       = req0_rhs;
        alu_operation = req0_op;
        alu_metadata  = req0_meta;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_id        <= 1'b0;
      out_illegal   <= 1'b0;
      illegal_count <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_id      <= grant_id;
      out_illegal <= !alu_code_legal;
      out_result  <= alu_code_legal ? alu_result : '0;
      // Loser of this grant is favoured on the next tie.
      ptr_q       <= ~grant_id;
      if (!alu_code_legal && (illegal_count != '1)) begin
        illegal_count <= illegal_count + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Testbench for alu_issue_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the arbiter. The bench
// also provides the shared ALU. A second instance with a 2-bit counter
// exercises counter saturation.
module tb_alu_issue_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] r_lhs [2];
  logic [31:0] r_rhs [2];
  logic [2:0]  r_op  [2];
  logic [6:0]  r_meta[2];
  logic [31:0] alu_lhs, alu_rhs, alu_result;
  logic [2:0]  alu_operation;
  logic [6:0]  alu_metadata;
  logic        alu_in_valid, alu_code_legal;
  logic        out_ready, out_valid, out_id, out_illegal;
  logic [31:0] out_result;
  logic [15:0] illegal_count;

  logic [1:0]  s_req_ready;
  logic [31:0] s_alu_lhs, s_alu_rhs, s_out_result;
  logic [2:0]  s_alu_operation;
  logic [6:0]  s_alu_metadata;
  logic        s_alu_in_valid, s_out_valid, s_out_id, s_out_illegal;
  logic [1:0]  s_illegal_count;

  alu_issue_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_lhs(r_lhs[0]), .req0_rhs(r_rhs[0]), .req0_op(r_op[0]), .req0_meta(r_meta[0]),
    .req1_lhs(r_lhs[1]), .req1_rhs(r_rhs[1]), .req1_op(r_op[1]), .req1_meta(r_meta[1]),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_operation(alu_operation),
    .alu_metadata(alu_metadata), .alu_in_valid(alu_in_valid),
    .alu_result(alu_result), .alu_code_legal(alu_code_legal),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_id(out_id), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  alu_issue_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req0_lhs(r_lhs[0]), .req0_rhs(r_rhs[0]), .req0_op(r_op[0]), .req0_meta(r_meta[0]),
    .req1_lhs(r_lhs[1]), .req1_rhs(r_rhs[1]), .req1_op(r_op[1]), .req1_meta(r_meta[1]),
    .alu_lhs(s_alu_lhs), .alu_rhs(s_alu_rhs), .alu_operation(s_alu_operation),
    .alu_metadata(s_alu_metadata), .alu_in_valid(s_alu_in_valid),
    .alu_result(alu_result), .alu_code_legal(alu_code_legal),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
    .out_id(s_out_id), .out_illegal(s_out_illegal), .illegal_count(s_illegal_count)
  );

  // RV32I register/immediate ALU: {legal, result}. Illegal codes return junk
  // so that a missing zeroing in the DUT is visible.
  function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [6:0] meta,
                                          input logic [31:0] a, input logic [31:0] b);
    logic        legal;
    logic [31:0] r;
    legal = 1'b1;
    r     = 32'h0;
    case (op)
      3'd0: if (meta == 7'h00) r = a + b; else if (meta == 7'h20) r = a - b; else legal = 1'b0;
      3'd1: if (meta == 7'h00) r = a << b[4:0]; else legal = 1'b0;
      3'd2: begin legal = (meta == 7'h00); r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      3'd3: begin legal = (meta == 7'h00); r = (a < b) ? 32'd1 : 32'd0; end
      3'd4: begin legal = (meta == 7'h00); r = a ^ b; end
      3'd5: if (meta == 7'h00) r = a >> b[4:0];
            else if (meta == 7'h20) r = 32'($signed(a) >>> b[4:0]);
            else legal = 1'b0;
      3'd6: begin legal = (meta == 7'h00); r = a | b; end
      default: begin legal = (meta == 7'h00); r = a & b; end
    endcase
    if (!legal) r = a ^ b ^ 32'hDEAD_BEEF;
    return {legal, r};
  endfunction

  always_comb {alu_code_legal, alu_result} = alu_ref(alu_operation, alu_metadata, alu_lhs, alu_rhs);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Transaction-level model: pending result slot, tie pointer, illegal tally.
  bit          m_ptr, m_ov, m_id, m_ill;
  logic [31:0] m_res;
  int          m_n;
  logic [1:0]  m_acc;

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_ov);
    check_eq("sat_out_valid", s_out_valid, m_ov);
    if (m_ov) begin
      check_eq("out_id", out_id, m_id);
      check_eq("out_result", out_result, m_res);
      check_eq("out_illegal", out_illegal, m_ill);
    end
    check_eq("illegal_count", illegal_count, (m_n > 65535) ? 65535 : m_n);
    check_eq("sat_illegal_count", s_illegal_count, (m_n > 3) ? 3 : m_n);
  endtask

  // Entered and left at a falling edge, with inputs already driven.
  task automatic step();
    bit          has, can, g;
    logic [32:0] ref_v;
    logic [1:0]  exp_rdy;
    #1;
    has = |req_valid;
    can = !m_ov || out_ready;
    g   = (req_valid == 2'b11) ? m_ptr : req_valid[1];
    exp_rdy = (has && can) ? (g ? 2'b10 : 2'b01) : 2'b00;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("sat_req_ready", s_req_ready, exp_rdy);
    check_eq("alu_in_valid", alu_in_valid, has);
    if (has) begin
      check_eq("alu_lhs", alu_lhs, r_lhs[g]);
      check_eq("alu_rhs", alu_rhs, r_rhs[g]);
      check_eq("alu_operation", alu_operation, r_op[g]);
      check_eq("alu_metadata", alu_metadata, r_meta[g]);
    end else begin
      check_eq("alu_lhs_idle", alu_lhs, 32'h0);
      check_eq("alu_rhs_idle", alu_rhs, 32'h0);
    end
    m_acc = exp_rdy;
    if (has && can) begin
      ref_v = alu_ref(r_op[g], r_meta[g], r_lhs[g], r_rhs[g]);
      m_ov  = 1'b1;
      m_id  = g;
      m_ill = !ref_v[32];
      m_res = ref_v[32] ? ref_v[31:0] : 32'h0;
      m_ptr = !g;
      if (!ref_v[32]) m_n++;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_ov = 1'b0; m_ptr = 1'b0; m_n = 0; m_id = 1'b0; m_ill = 1'b0; m_res = 32'h0;
    m_acc = 2'b00;
    check_outputs();
    check_eq("rst_out_result", out_result, 32'h0);
    check_eq("rst_out_id", out_id, 32'h0);
    check_eq("rst_out_illegal", out_illegal, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [2:0] op, input logic [6:0] meta,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v;
    r_op[i]      = op;
    r_meta[i]    = meta;
    r_lhs[i]     = a;
    r_rhs[i]     = b;
  endtask

  task automatic rand_req(input int i);
    int pick;
    pick = int'($urandom_range(0, 9));
    set_req(i, 1'b1, 3'($urandom_range(0, 7)),
            (pick < 6) ? 7'h00 : (pick < 9) ? 7'h20 : 7'($urandom),
            $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    req_valid = 2'b00;
    set_req(0, 1'b0, 3'd0, 7'h00, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'd0, 7'h00, 32'h0, 32'h0);
    @(negedge clk);
    do_reset();

    // Single ADD from requester 0.
    out_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 7'h00, 32'd5, 32'd7);
    step();
    check_eq("t1_result", out_result, 32'd12);
    req_valid = 2'b00;
    step();

    // Continuous tie: SUB vs XOR must alternate.
    set_req(0, 1'b1, 3'd0, 7'h20, 32'd10, 32'd3);
    set_req(1, 1'b1, 3'd4, 7'h00, 32'hF0, 32'h0F);
    for (int k = 0; k < 4; k++) step();

    // Backpressure for 5 cycles, then drain and accept in the same cycle.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    out_ready = 1'b1;
    step();
    req_valid = 2'b00;
    step();

    // Illegal op (SLL with funct7 0x20), six times; 2-bit counter saturates.
    set_req(1, 1'b1, 3'd1, 7'h20, 32'h1234, 32'd2);
    for (int k = 0; k < 6; k++) step();
    req_valid = 2'b00;
    step();

    // Reset with a stalled result pending; tie afterwards goes to requester 0.
    set_req(0, 1'b1, 3'd0, 7'h00, 32'd1, 32'd2);
    set_req(1, 1'b1, 3'd0, 7'h00, 32'd3, 32'd4);
    step();
    out_ready = 1'b0;
    step();
    do_reset();
    out_ready = 1'b1;
    step();
    check_eq("t5_tie_after_reset", m_acc, 2'b01);
    req_valid = 2'b00;
    step();

    // Shift and compare corner cases.
    set_req(0, 1'b1, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    step();
    check_eq("t6_sra", out_result, 32'hF800_0000);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1);
    step();
    check_eq("t6_slt", out_result, 32'd1);
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 3'd3, 7'h00, 32'd1, 32'hFFFF_FFFF);
    step();
    check_eq("t6_sltu", out_result, 32'd1);
    req_valid = 2'b00;
    step();

    // Random traffic; requesters hold fields until accepted.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !m_acc[i])) begin
          if ($urandom_range(0, 3) != 0) rand_req(i);
          else req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
